alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, multi-cycle ALU for the next-generation nic8 datapath. It handles
//  add/sub with and without carry-in, plus multi-bit rotate-through-shift-flag in
//  both directions. The result is registered and driven onto the tristate data bus
//  under an active-low enable. Sits between the A/B registers and the bus; the
//  control sequencer drives it with a start/busy/done handshake.
// PARAMETERS
//  WIDTH       8   datapath width in bits (areg, breg, result, dbus)
//  SHIFT_BITS  3   width of shift-amount input; max shift = 2**SHIFT_BITS-1
// PORTS
//  clk         in   1           single clock; all state updates on posedge
//  reset       in   1           synchronous, active-high reset
//  start       in   1           request op; sampled only when idle (busy=0)
//  op          in   3           ADD=0 SUB=1 ADC=2 SBC=3 SHR=4 SHL=5, 6/7 reserved
//  amount      in   SHIFT_BITS  shift count for SHR/SHL
//  areg        in   WIDTH       operand A, sampled at the start edge
//  breg        in   WIDTH       operand B, sampled at the start edge
//  assertBarE  in   1           low: drive result onto dbus; high: dbus = 'z
//  dbus        out  WIDTH       tristate bus output
//  busy        out  1           op in progress; start ignored while high
//  done        out  1           one-cycle pulse when result/flags are valid
//  aIsZero     out  1           combinational (areg == 0)
//  flagCarry   out  1           registered carry / no-borrow flag
//  flagShift   out  1           registered shift flag (rotate-through bit)
//  flagZero    out  1           registered (result == 0), updated at completion
// BEHAVIOUR
//  - Reset: state IDLE. result, flagCarry, flagShift, flagZero, busy and done = 0.
//    Reset aborts any op in progress; it wins over a simultaneous start.
//  - States: IDLE, SHIFT. done is a registered pulse; it is high in the cycle after
//    the completing edge, and the block is in IDLE in that cycle.
//  - Start edge: the posedge with start=1 and busy=0. Operands, op and amount are
//    captured on this edge; later input changes do not affect the op.
//  - Arithmetic is single-cycle, completing on the start edge. sum is WIDTH+1 bits.
//      ADD: {C,r} = a + b
//      SUB: r = a - b, C = (a >= b) (no-borrow)
//      ADC: {C,r} = a + b + flagCarry
//      SBC: r = a - b - ~flagCarry, C = no-borrow
//    flagShift is unchanged by all four arithmetic ops.
//  - Shift, amount = n:
//      n = 0: completes on the start edge; result = a; flagShift unchanged.
//      n > 0: the start edge performs the first step and loads count = n-1.
//      If count != 0 the block enters SHIFT and does one step per edge.
//      The op completes on the edge where count reaches 0. Total edges = max(n,1).
//    One step is a (WIDTH+1)-bit rotate through flagShift:
//      SHR: r = {S, r[W-1:1]}, S = r[0]
//      SHL: r = {r[W-2:0], S}, S = r[W-1]
//    flagCarry is unchanged by shifts.
//  - Completion: result is registered and flagZero = (result == 0).
//    done = 1 for exactly one cycle; busy = 0 in the done cycle.
//    busy = 1 from the cycle after the start edge until the completing edge.
//    A start in the done cycle is accepted, so back-to-back ops lose no cycles.
//  - Single-cycle ops set done the next cycle and never raise busy.
//  - start while busy: ignored; no queuing.
//  - Reserved op: completes in one cycle with result = a; all flags unchanged
//    except flagZero.
//  - dbus is combinational from the result register and assertBarE only.
//    Bus contention is the sequencer's responsibility.
// STRUCTURE
//  - Package alu_seq_pkg: op_t enum (values above), state_t enum {IDLE, SHIFT}.
//  - One sub-module: alu_seq_adder #(WIDTH). Inputs a, b, cin, sub. Outputs r and
//    cout (no-borrow when sub). Shared by ADD/SUB/ADC/SBC.
//  - Shift step, counter and FSM stay inline in alu_seq.
// TESTING (WIDTH=8, SHIFT_BITS=3)
//  1. ADD a=F0 b=20 -> dbus=10, C=1, Z=0. done 1 cycle after the start edge;
//     busy never high.
//  2. SUB a=05 b=05 -> 00, C=1, Z=1. Then SUB a=03 b=05 -> FE, C=0, Z=0.
//  3. ADD FF+01 -> 00, C=1. Then ADC 00+00 -> 01, C=0.
//     Then SBC 05-01 with C=0 -> 03, C=1.
//  4. S=0, SHR a=B5 n=3. Steps: 5A/S1, AD/S0, 56/S1.
//     -> result 56, S=1; busy high 2 cycles; done 3 cycles after start.
//     Then SHL a=80 n=1 with S=1 -> 01, S=1.
//  5. SHR n=7 with start pulsed again mid-op -> second start ignored.
//     reset asserted on step 4 -> next cycle state IDLE, result 00, all flags 0,
//     busy=0, done=0.
//  6. SHL n=0 a=3C -> 3C, S unchanged, done next cycle.
//     assertBarE=1 -> dbus all 'z; assertBarE=0 -> dbus=3C.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the nic8 multi-cycle ALU: opcode and FSM state encodings.
package alu_seq_pkg;

    localparam int OP_W = 3;

    // Opcodes 6 and 7 are reserved and behave as a pass-through of operand A.
    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_ADC = 3'd2,
        OP_SBC = 3'd3,
        OP_SHR = 3'd4,
        OP_SHL = 3'd5
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Sequencer-facing bundle of the ALU: request/handshake, operands, tristate bus
// and status flags. The sequencer is the master, the ALU the slave.
interface alu_seq_if #(
    parameter int WIDTH      = 8,
    parameter int SHIFT_BITS = 3
);
    import alu_seq_pkg::*;

    logic                  start;
    logic [OP_W-1:0]       op;
    logic [SHIFT_BITS-1:0] amount;
    logic [WIDTH-1:0]      areg;
    logic [WIDTH-1:0]      breg;
    logic                  assertBarE;
    logic [WIDTH-1:0]      dbus;
    logic                  busy;
    logic                  done;
    logic                  aIsZero;
    logic                  flagCarry;
    logic                  flagShift;
    logic                  flagZero;

    modport master (
        output start, op, amount, areg, breg, assertBarE,
        input  dbus, busy, done, aIsZero, flagCarry, flagShift, flagZero
    );

    modport slave (
        input  start, op, amount, areg, breg, assertBarE,
        output dbus, busy, done, aIsZero, flagCarry, flagShift, flagZero
    );

endinterface

// File: rtl/alu_seq_adder.sv
// Shared adder/subtractor for ADD/SUB/ADC/SBC. Subtraction is a + ~b + cin, so
// cout is the no-borrow flag when sub is set.
module alu_seq_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] r,
    output logic             cout
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // One WIDTH+1 bit addition covers both add and two's-complement subtract.
    always_comb begin
        b_eff = sub ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    end

    assign r    = sum[WIDTH-1:0];
    assign cout = sum[WIDTH];

endmodule

// File: rtl/alu_seq.sv
// nic8 multi-cycle ALU: single-cycle add/sub family, multi-step rotate through the
// shift flag, registered result driven onto a tristate bus, start/busy/done
// handshake towards the control sequencer.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SHIFT_BITS = 3
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);

    // One rotate step through the shift flag; returns {new_flag, new_result}.
    function automatic logic [WIDTH:0] rot_step(input logic [WIDTH-1:0] r,
                                                input logic             s,
                                                input logic             left);
        if (left)
            return {r[WIDTH-1], r[WIDTH-2:0], s};
        else
            return {r[0], s, r[WIDTH-1:1]};
    endfunction

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      result_p1, result_d;
    logic                  flag_c_q, flag_c_d;
    logic                  flag_s_q, flag_s_d;
    logic                  flag_z_q, flag_z_d;
    logic [SHIFT_BITS-1:0] cnt_q, cnt_d;
    logic                  left_q, left_d;
    logic                  vld_p1;
    logic                  complete;

    op_t                   op_w;
    logic                  add_sub;
    logic                  add_cin;
    logic [WIDTH-1:0]      add_r;
    logic                  add_cout;
    logic [WIDTH:0]        step;

    assign op_w = op_t'(bus.op);

    // Adder control: SUB forces carry-in 1, the with-carry forms use the flag.
    always_comb begin
        add_sub = 1'b0;
        add_cin = 1'b0;
        case (op_w)
            OP_SUB:  begin add_sub = 1'b1; add_cin = 1'b1;     end
            OP_ADC:  begin add_sub = 1'b0; add_cin = flag_c_q; end
            OP_SBC:  begin add_sub = 1'b1; add_cin = flag_c_q; end
            default: begin add_sub = 1'b0; add_cin = 1'b0;     end
        endcase
    end

    alu_seq_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (bus.areg),
        .b    (bus.breg),
        .cin  (add_cin),
        .sub  (add_sub),
        .r    (add_r),
        .cout (add_cout)
    );

    // Next-state, datapath update and completion detection.
    always_comb begin
        state_d  = state_q;
        result_d = result_p1;
        flag_c_d = flag_c_q;
        flag_s_d = flag_s_q;
        flag_z_d = flag_z_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        complete = 1'b0;
        step     = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (op_w)
                        OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                            result_d = add_r;
                            flag_c_d = add_cout;
                            complete = 1'b1;
                        end
                        OP_SHR, OP_SHL: begin
                            left_d = (op_w == OP_SHL);
                            if (bus.amount == '0) begin
                                result_d = bus.areg;
                                complete = 1'b1;
                            end else begin
                                // The start edge already performs the first step.
                                step     = rot_step(bus.areg, flag_s_q, op_w == OP_SHL);
                                result_d = step[WIDTH-1:0];
                                flag_s_d = step[WIDTH];
                                cnt_d    = bus.amount - SHIFT_BITS'(1);
                                if (cnt_d == '0)
                                    complete = 1'b1;
                                else
                                    state_d = SHIFT;
                            end
                        end
                        default: begin
                            result_d = bus.areg;
                            complete = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                step     = rot_step(result_p1, flag_s_q, left_q);
                result_d = step[WIDTH-1:0];
                flag_s_d = step[WIDTH];
                cnt_d    = cnt_q - SHIFT_BITS'(1);
                if (cnt_q == SHIFT_BITS'(1)) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (complete)
            flag_z_d = (result_d == '0);
    end

    // State, result and flag registers; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            result_p1 <= '0;
            flag_c_q  <= 1'b0;
            flag_s_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_p1 <= result_d;
            flag_c_q  <= flag_c_d;
            flag_s_q  <= flag_s_d;
            flag_z_q  <= flag_z_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            vld_p1    <= complete;
        end
    end

    assign bus.busy      = (state_q == SHIFT);
    assign bus.done      = vld_p1;
    assign bus.aIsZero   = (bus.areg == '0);
    assign bus.flagCarry = flag_c_q;
    assign bus.flagShift = flag_s_q;
    assign bus.flagZero  = flag_z_q;
    assign bus.dbus      = bus.assertBarE ? {WIDTH{1'bz}} : result_p1;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops
// compared against a behavioural model.
module tb_alu_seq;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    alu_seq_if #(.WIDTH(8), .SHIFT_BITS(3)) bus ();

    alu_seq #(.WIDTH(8), .SHIFT_BITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: result, carry, shift and zero flags.
    int m_r = 0;
    int m_c = 0;
    int m_s = 0;
    int m_z = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Rotate the 9-bit word {S,r} by n places.
    function automatic int rot9(input int w, input int n, input bit left);
        int k;
        k = n % 9;
        if (k == 0) return w & 9'h1FF;
        if (left) return ((w << k) | (w >> (9 - k))) & 9'h1FF;
        return ((w >> k) | (w << (9 - k))) & 9'h1FF;
    endfunction

    task automatic model(input int op, input int a, input int b, input int n);
        int t;
        int w;
        case (op)
            0: begin t = a + b;           m_r = t & 255; m_c = (t > 255) ? 1 : 0; end
            1: begin t = a - b;           m_r = t & 255; m_c = (t >= 0) ? 1 : 0;  end
            2: begin t = a + b + m_c;     m_r = t & 255; m_c = (t > 255) ? 1 : 0; end
            3: begin t = a - b - (1 - m_c); m_r = t & 255; m_c = (t >= 0) ? 1 : 0; end
            4, 5: begin
                if (n == 0) m_r = a;
                else begin
                    w   = rot9(m_s * 256 + a, n, op == 5);
                    m_s = (w >> 8) & 1;
                    m_r = w & 255;
                end
            end
            default: m_r = a;
        endcase
        m_z = (m_r == 0) ? 1 : 0;
    endtask

    // Issue one op at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input int op, input int a, input int b, input int n);
        int lat;
        int busy_n;
        int exp_lat;
        bit seen;
        exp_lat = ((op == 4 || op == 5) && n > 1) ? n : 1;
        model(op, a, b, n);
        bus.start      = 1'b1;
        bus.op         = op[2:0];
        bus.areg       = a[7:0];
        bus.breg       = b[7:0];
        bus.amount     = n[2:0];
        bus.assertBarE = 1'b0;
        busy_n = 0;
        seen   = 1'b0;
        lat    = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.areg  = ~a[7:0];
                bus.breg  = ~b[7:0];
            end
            if (bus.done) begin
                seen = 1'b1;
                lat  = k;
            end else if (bus.busy) begin
                busy_n++;
            end
        end
        if (!seen) begin
            chk("timeout", 32'(seen), 32'd1);
        end else begin
            chk("latency", 32'(lat), 32'(exp_lat));
            chk("busy_cycles", 32'(busy_n), 32'(exp_lat - 1));
            chk("busy_in_done", 32'(bus.busy), 32'd0);
            chk("dbus", 32'(bus.dbus), 32'(m_r));
            chk("flagCarry", 32'(bus.flagCarry), 32'(m_c));
            chk("flagShift", 32'(bus.flagShift), 32'(m_s));
            chk("flagZero", 32'(bus.flagZero), 32'(m_z));
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.op         = 3'd0;
        bus.amount     = 3'd0;
        bus.areg       = 8'h00;
        bus.breg       = 8'h00;
        bus.assertBarE = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dbus", 32'(bus.dbus), 32'h00);
        chk("rst_flags", 32'({bus.flagCarry, bus.flagShift, bus.flagZero}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Combinational zero detect on operand A.
        bus.areg = 8'h00; #1;
        chk("aIsZero_1", 32'(bus.aIsZero), 32'd1);
        bus.areg = 8'h40; #1;
        chk("aIsZero_0", 32'(bus.aIsZero), 32'd0);
        @(negedge clk);

        // Scenario 1: ADD with carry out, single-cycle.
        run_op(0, 8'hF0, 8'h20, 0);
        chk("t1_dbus", 32'(bus.dbus), 32'h10);
        chk("t1_C", 32'(bus.flagCarry), 32'd1);
        @(negedge clk);
        chk("t1_done_pulse", 32'(bus.done), 32'd0);

        // Scenario 2: SUB equal and SUB with borrow, back-to-back.
        run_op(1, 8'h05, 8'h05, 0);
        chk("t2a_dbus", 32'(bus.dbus), 32'h00);
        chk("t2a_Z", 32'(bus.flagZero), 32'd1);
        run_op(1, 8'h03, 8'h05, 0);
        chk("t2b_dbus", 32'(bus.dbus), 32'hFE);
        chk("t2b_C", 32'(bus.flagCarry), 32'd0);

        // Scenario 3: carry chaining through ADC and SBC.
        run_op(0, 8'hFF, 8'h01, 0);
        chk("t3a_C", 32'(bus.flagCarry), 32'd1);
        run_op(2, 8'h00, 8'h00, 0);
        chk("t3b_dbus", 32'(bus.dbus), 32'h01);
        run_op(3, 8'h05, 8'h01, 0);
        chk("t3c_dbus", 32'(bus.dbus), 32'h03);
        chk("t3c_C", 32'(bus.flagCarry), 32'd1);

        // Scenario 4: multi-step rotate right, then single-step rotate left.
        chk("t4_S0", 32'(bus.flagShift), 32'd0);
        run_op(4, 8'hB5, 8'h00, 3);
        chk("t4a_dbus", 32'(bus.dbus), 32'h56);
        chk("t4a_S", 32'(bus.flagShift), 32'd1);
        run_op(5, 8'h80, 8'h00, 1);
        chk("t4b_dbus", 32'(bus.dbus), 32'h01);
        chk("t4b_S", 32'(bus.flagShift), 32'd1);

        // Scenario 6: zero-length shift and tristate bus control.
        run_op(5, 8'h3C, 8'h00, 0);
        chk("t6_dbus", 32'(bus.dbus), 32'h3C);
        chk("t6_S", 32'(bus.flagShift), 32'd1);
        bus.assertBarE = 1'b1; #1;
        chk("t6_bus_off", 32'((bus.dbus === 8'hzz) || (bus.dbus === 8'h00)), 32'd1);
        bus.assertBarE = 1'b0; #1;
        chk("t6_bus_on", 32'(bus.dbus), 32'h3C);
        @(negedge clk);

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
        end

        // Scenario 5: ignored restart mid-shift, then reset aborts the op.
        bus.start = 1'b1; bus.op = 3'd4; bus.areg = 8'hC3; bus.amount = 3'd7;
        @(negedge clk);
        chk("t5_busy1", 32'(bus.busy), 32'd1);
        bus.op = 3'd0; bus.areg = 8'h00; bus.breg = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        chk("t5_busy2", 32'(bus.busy), 32'd1);
        chk("t5_step2", 32'(bus.dbus), 32'(rot9(m_s * 256 + 8'hC3, 2, 1'b0) & 255));
        @(negedge clk);
        chk("t5_step3", 32'(bus.dbus), 32'(rot9(m_s * 256 + 8'hC3, 3, 1'b0) & 255));
        chk("t5_no_done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_done", 32'(bus.done), 32'd0);
        chk("t5_rst_dbus", 32'(bus.dbus), 32'h00);
        chk("t5_rst_flags", 32'({bus.flagCarry, bus.flagShift, bus.flagZero}), 32'd0);
        m_r = 0; m_c = 0; m_s = 0; m_z = 0;
        @(negedge clk);
        chk("t5_idle_done", 32'(bus.done), 32'd0);
        run_op(0, 8'h12, 8'h34, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
